// File: rtl/seq_gen_pkg.sv
// seq_pkg: shared types for the serial pattern transmitter.
//   det_state_t : shadow copy of the 3-bit sequence-detector states S_0..S_7
//   tx_state_t  : transmitter controller states
//   det_next()  : one step of the detector state graph for a given input bit
package seq_pkg;

   typedef enum logic [2:0] {
      S_0 = 3'd0,
      S_1 = 3'd1,
      S_2 = 3'd2,
      S_3 = 3'd3,
      S_4 = 3'd4,
      S_5 = 3'd5,
      S_6 = 3'd6,
      S_7 = 3'd7
   } det_state_t;

   // GAP_WAIT is not called GAP so it cannot collide with the GAP parameter.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SYNC     = 3'd1,
      SHIFT    = 3'd2,
      DONE     = 3'd3,
      GAP_WAIT = 3'd4
   } tx_state_t;

   // Detector graph, written as (state, bit) -> next state.
   function automatic det_state_t det_next(input det_state_t s, input logic b);
      case (s)
         S_0:     return b ? S_1 : S_2;
         S_1:     return b ? S_1 : S_4;
         S_2:     return b ? S_4 : S_3;
         S_3:     return b ? S_5 : S_6;
         S_4:     return b ? S_4 : S_5;
         S_5:     return b ? S_5 : S_7;
         S_6:     return b ? S_7 : S_6;
         S_7:     return S_7;
         default: return S_0;
      endcase
   endfunction

endpackage

// File: rtl/seq_gen_shadow.sv
// seq_shadow: shadow register tracking the downstream detector state.
//   clk   : system clock
//   rst   : synchronous active-high reset (state -> S_0)
//   clr   : load S_0 (asserted during the state-reset strobe cycle)
//   en    : advance one step using din (asserted while a bit is emitted)
//   din   : the bit currently on the serial line
//   state : current shadow state
module seq_shadow
   import seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output det_state_t state
);

   det_state_t state_reg;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_reg <= S_0;
      end else if (en) begin
         state_reg <= det_next(state_reg, din);
      end
   end

   assign state = state_reg;

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter driving a 3-bit sequence detector.
// Accepts a 1..W bit word over valid/ready, emits a one-cycle state-reset
// strobe, then the word MSB-first, and reports whether a shadow copy of the
// detector reached S_7 at the end of the frame.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : upstream handshake (ready only in IDLE)
//   in_word, in_len   : frame bits and length (0 or >W means W)
//   out_data          : serial bit to detector
//   out_state_reset   : strobe to detector state reset
//   out_busy          : frame in progress
//   out_shadow_state  : shadow detector state
//   frame_done        : one-cycle end-of-frame pulse
//   frame_hit         : with frame_done, 1 if shadow state is S_7
module seq_gen
   import seq_pkg::*;
#(
   parameter int W     = 8,
   parameter int LEN_W = $clog2(W + 1),
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_word,
   input  logic [LEN_W-1:0] in_len,
   output logic             out_data,
   output logic             out_state_reset,
   output logic             out_busy,
   output logic [2:0]       out_shadow_state,
   output logic             frame_done,
   output logic             frame_hit
);

   // The gap counter is loaded with GAP-1 so that GAP_WAIT lasts GAP cycles.
   localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   tx_state_t        state_reg, state_next;
   logic [W-1:0]     shift_reg, shift_next;
   logic [LEN_W-1:0] cnt_reg,   cnt_next;
   logic [3:0]       gap_reg,   gap_next;
   logic [LEN_W-1:0] len_eff;
   det_state_t       shadow_state;

   assign len_eff = (in_len == '0 || int'(in_len) > W) ? LEN_W'(W) : in_len;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         cnt_reg   <= '0;
         gap_reg   <= '0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         cnt_reg   <= cnt_next;
         gap_reg   <= gap_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      shift_next      = shift_reg;
      cnt_next        = cnt_reg;
      gap_next        = gap_reg;
      in_ready        = 1'b0;
      out_busy        = 1'b1;
      out_state_reset = 1'b0;
      out_data        = 1'b0;
      frame_done      = 1'b0;
      frame_hit       = 1'b0;

      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            out_busy = 1'b0;
            if (in_valid) begin
               // Left-align the frame so bit L-1 sits in the MSB; SHIFT then
               // always transmits shift_reg[W-1].
               shift_next = in_word << (W - int'(len_eff));
               cnt_next   = len_eff;
               state_next = SYNC;
            end
         end
         SYNC: begin
            out_state_reset = 1'b1;
            state_next      = SHIFT;
         end
         SHIFT: begin
            out_data   = shift_reg[W-1];
            shift_next = shift_reg << 1;
            cnt_next   = cnt_reg - 1'b1;
            if (cnt_reg == LEN_W'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            frame_hit  = (shadow_state == S_7);
            if (GAP > 0) begin
               gap_next   = GAP_LOAD;
               state_next = GAP_WAIT;
            end else begin
               state_next = IDLE;
            end
         end
         GAP_WAIT: begin
            if (gap_reg == 4'd0) begin
               state_next = IDLE;
            end else begin
               gap_next = gap_reg - 4'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   seq_shadow u_shadow (
      .clk   (clk),
      .rst   (rst),
      .clr   (state_reg == SYNC),
      .en    (state_reg == SHIFT),
      .din   (shift_reg[W-1]),
      .state (shadow_state)
   );

   assign out_shadow_state = shadow_state;

endmodule

// File: tb/tb_seq_gen.sv
`timescale 1ns/1ps
module tb_seq_gen;

   localparam int W     = 8;
   localparam int LEN_W = 4;
   localparam int GAP   = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [W-1:0]     in_word = '0;
   logic [LEN_W-1:0] in_len = '0;
   logic             in_ready, out_data, out_state_reset, out_busy;
   logic [2:0]       out_shadow_state;
   logic             frame_done, frame_hit;

   seq_gen #(.W(W), .GAP(GAP)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_word          (in_word),
      .in_len           (in_len),
      .out_data         (out_data),
      .out_state_reset  (out_state_reset),
      .out_busy         (out_busy),
      .out_shadow_state (out_shadow_state),
      .frame_done       (frame_done),
      .frame_hit        (frame_hit)
   );

   always #5 clk = ~clk;

   // Frame vectors: inputs plus expected hit and final shadow state.
   typedef struct {
      logic [W-1:0]     word;
      logic [LEN_W-1:0] len;
      logic             hit;
      logic [2:0]       fin;
   } vec_t;

   // One expected output cycle: {ready,busy,state_reset,data,done,hit}, shadow.
   // act: 0 none, 1 drop in_valid, 2 present the queued next word.
   typedef struct {
      logic [5:0] sig;
      logic [2:0] sh;
      int         act;
      string      tag;
   } exp_t;

   exp_t             sb[$];
   vec_t             vecs[8];
   int               n_tests = 0;
   int               n_fail  = 0;
   logic [2:0]       model_sh = 3'd0;
   logic [W-1:0]     next_word = '0;
   logic [LEN_W-1:0] next_len = '0;

   function automatic logic [2:0] ref_next(input logic [2:0] s, input logic b);
      logic [2:0] r;
      case (s)
         3'd0: r = b ? 3'd1 : 3'd2;
         3'd1: r = b ? 3'd1 : 3'd4;
         3'd2: r = b ? 3'd4 : 3'd3;
         3'd3: r = b ? 3'd5 : 3'd6;
         3'd4: r = b ? 3'd4 : 3'd5;
         3'd5: r = b ? 3'd5 : 3'd7;
         3'd6: r = b ? 3'd7 : 3'd6;
         default: r = 3'd7;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got {rdy,busy,sr,data,done,hit,sh}=%b expected %b", name, got, want);
      end else begin
         $display("[TB] ok %s: %b", name, got);
      end
   endtask

   task automatic push(input logic [5:0] sig, input logic [2:0] sh, input int act, input string tag);
      exp_t e;
      e.sig = sig;
      e.sh  = sh;
      e.act = act;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Expected cycles from SYNC through the last GAP cycle of one frame.
   task automatic push_frame(input logic [W-1:0] word, input logic [LEN_W-1:0] len,
                             input logic hit, input logic [2:0] fin, input int act_sync);
      int         l;
      logic [2:0] s;
      logic       b;
      l = (len == 0 || int'(len) > W) ? W : int'(len);
      push({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, model_sh, act_sync, "sync");
      s = 3'd0;
      for (int k = l - 1; k >= 0; k--) begin
         b = word[k];
         push({1'b0, 1'b1, 1'b0, b, 1'b0, 1'b0}, s, 0, $sformatf("bit%0d", k));
         s = ref_next(s, b);
      end
      push({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, hit}, fin, 0, "done");
      for (int g = 0; g < GAP; g++) begin
         push({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, fin, 0, "gap");
      end
      model_sh = fin;
   endtask

   task automatic push_idle(input int act);
      push({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, model_sh, act, "idle");
   endtask

   // Pop and compare one expected record per cycle, on the falling edge.
   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         check(e.tag, {in_ready, out_busy, out_state_reset, out_data, frame_done, frame_hit,
                       out_shadow_state}, {e.sig, e.sh});
         if (e.act == 1) begin
            in_valid = 1'b0;
         end else if (e.act == 2) begin
            in_word = next_word;
            in_len  = next_len;
         end
      end
   endtask

   // Present a word; the next rising edge accepts it.
   task automatic start(input logic [W-1:0] word, input logic [LEN_W-1:0] len);
      int i;
      for (i = 0; i < 30 && !in_ready; i++) @(negedge clk);
      n_tests++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL start_ready: got in_ready=%b expected 1 within 30 cycles", in_ready);
      end
      in_valid = 1'b1;
      in_word  = word;
      in_len   = len;
   endtask

   task automatic run_vec(input vec_t v);
      $display("[TB] frame word=%h len=%0d", v.word, v.len);
      start(v.word, v.len);
      push_frame(v.word, v.len, v.hit, v.fin, 1);
      push_idle(0);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h01, 4'd4,  1'b1, 3'd7};  // hit via S_2,S_3,S_6,S_7
      vecs[1] = '{8'hFF, 4'd8,  1'b0, 3'd1};  // all ones: stays S_1
      vecs[2] = '{8'hA5, 4'd0,  1'b1, 3'd7};  // len 0 clamps to 8
      vecs[3] = '{8'h05, 4'd15, 1'b1, 3'd7};  // len >W clamps to 8
      vecs[4] = '{8'hF0, 4'd1,  1'b0, 3'd2};  // single bit 0
      vecs[5] = '{8'h02, 4'd3,  1'b0, 3'd5};  // 0,1,0
      vecs[6] = '{8'h0C, 4'd4,  1'b0, 3'd5};  // 1,1,0,0
      vecs[7] = '{8'h80, 4'd8,  1'b1, 3'd7};  // 1 then zeros

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset", {in_ready, out_busy, out_state_reset, out_data, frame_done, frame_hit,
                      out_shadow_state}, 9'b100000_000);
      model_sh = 3'd0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Back-to-back: in_valid held, A then B; B accepted on first IDLE cycle.
      $display("[TB] back-to-back A=01/4 B=FF/2");
      next_word = 8'hFF;
      next_len  = 4'd2;
      start(8'h01, 4'd4);
      push_frame(8'h01, 4'd4, 1'b1, 3'd7, 2);
      push_idle(0);
      push_frame(8'hFF, 4'd2, 1'b0, 3'd1, 1);
      push_idle(0);
      drain();

      // Mid-frame reset during the 2nd SHIFT cycle.
      $display("[TB] mid-frame reset");
      start(8'h01, 4'd4);
      @(negedge clk);                       // SYNC
      in_valid = 1'b0;
      check("mr_sync", {in_ready, out_busy, out_state_reset, out_data, frame_done, frame_hit,
                        out_shadow_state}, {6'b011000, model_sh});
      @(negedge clk);                       // first SHIFT
      @(negedge clk);                       // second SHIFT
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mr_after", {in_ready, out_busy, out_state_reset, out_data, frame_done, frame_hit,
                         out_shadow_state}, 9'b100000_000);
      model_sh = 3'd0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("mr_idle%0d", c), {in_ready, out_busy, out_state_reset, out_data,
               frame_done, frame_hit, out_shadow_state}, 9'b100000_000);
      end
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
